// File: rtl/ddr_cmd_sequencer.sv
// DDR1 x16 command sequencer: power-up init, periodic auto-refresh, closed-page ACT -> RD/WR with auto-precharge.
// Optional build macro DDR_STAT_CNT_EN adds saturating accepted-request and refresh counters.
`timescale 1ns/1ps
module ddr_cmd_sequencer #(
  parameter int CAS_LAT      = 2,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_WR         = 2,
  parameter int T_RFC        = 8,
  parameter int REF_INTERVAL = 780,
  parameter int INIT_WAIT    = 20000,
  parameter int PHY_RD_LAT   = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [20:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        init_done,
  output logic        sd_cke,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_ba,
  output logic [10:0] sd_addr,
  output logic        wr_dq_en,
  output logic [15:0] wr_dq_p,
  output logic [15:0] wr_dq_n,
  output logic [1:0]  wr_dm_p,
  output logic [1:0]  wr_dm_n,
  input  logic [15:0] rd_dq_p,
  input  logic [15:0] rd_dq_n
`ifdef DDR_STAT_CNT_EN
  ,
  output logic [15:0] stat_req_cnt,
  output logic [15:0] stat_ref_cnt
`endif
);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [15:0] INIT_RELOAD = 16'(INIT_WAIT - 1);
  localparam logic [15:0] REF_RELOAD  = 16'(REF_INTERVAL - 1);
  localparam logic [15:0] RCD_W       = 16'(T_RCD - 1);
  localparam logic [15:0] RD_W        = 16'(CAS_LAT + PHY_RD_LAT - 1);
  localparam logic [15:0] RP_W        = 16'(T_RP - 1);
  localparam logic [15:0] WRP_W       = 16'(T_WR + T_RP - 2);
  localparam logic [15:0] RFC_W       = 16'(T_RFC - 1);
  localparam logic [10:0] MRS_DLL_RST = 11'h100 | 11'(CAS_LAT << 4) | 11'h001;
  localparam logic [10:0] MRS_NORM    = 11'(CAS_LAT << 4) | 11'h001;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_SEQ, S_IDLE, S_ACT, S_RDWR, S_RD_DATA, S_WR_DATA, S_PRE_WAIT, S_REF
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q, ref_cnt_q, ref_cnt_d;
  logic [2:0]  step_q;
  logic        cke_q, init_done_q, ref_pend_q, ref_expire, accept;
  logic [3:0]  cmd_q;
  logic [1:0]  ba_q;
  logic [10:0] addr_q;
  logic        wr_q;
  logic [20:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic [3:0]  lat_be_q;
  logic        rsp_valid_q, wr_dq_en_q;
  logic [31:0] rsp_rdata_q;
  logic [15:0] wr_dq_p_q, wr_dq_n_q;
  logic [1:0]  wr_dm_p_q, wr_dm_n_q;
  logic [3:0]  seq_cmd;
  logic [1:0]  seq_ba;
  logic [10:0] seq_addr;
  logic [15:0] seq_wait;

  assign req_ready = (state_q == S_IDLE) & init_done_q & ~ref_pend_q;
  assign accept    = req_valid & req_ready;

  always_comb begin
    ref_expire = 1'b0;
    ref_cnt_d  = ref_cnt_q;
    if (!init_done_q) begin
      ref_cnt_d = REF_RELOAD;
    end else if (ref_cnt_q == 16'd0) begin
      ref_cnt_d  = REF_RELOAD;
      ref_expire = 1'b1;
    end else begin
      ref_cnt_d = ref_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) ref_cnt_q <= REF_RELOAD;
    else        ref_cnt_q <= ref_cnt_d;
  end

  // Init command table: each entry carries its own post-command wait (minus one).
  always_comb begin
    seq_cmd  = CMD_NOP;
    seq_ba   = 2'b00;
    seq_addr = 11'h000;
    seq_wait = 16'd0;
    case (step_q)
      3'd0, 3'd3: begin seq_cmd = CMD_PRE; seq_addr = 11'h400; seq_wait = RP_W; end
      3'd1:       begin seq_cmd = CMD_MRS; seq_ba = 2'b01; seq_wait = 16'd1; end
      3'd2:       begin seq_cmd = CMD_MRS; seq_addr = MRS_DLL_RST; seq_wait = 16'd1; end
      3'd4, 3'd5: begin seq_cmd = CMD_REF; seq_wait = RFC_W; end
      3'd6:       begin seq_cmd = CMD_MRS; seq_addr = MRS_NORM; seq_wait = 16'd199; end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_INIT_WAIT;
      cnt_q       <= INIT_RELOAD;
      step_q      <= 3'd0;
      cke_q       <= 1'b0;
      init_done_q <= 1'b0;
      ref_pend_q  <= 1'b0;
      cmd_q       <= CMD_DESEL;
      ba_q        <= 2'b00;
      addr_q      <= 11'h000;
      wr_q        <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_dq_en_q  <= 1'b0;
      wr_dq_p_q   <= '0;
      wr_dq_n_q   <= '0;
      wr_dm_p_q   <= '0;
      wr_dm_n_q   <= '0;
    end else begin
      cmd_q       <= CMD_NOP;
      rsp_valid_q <= 1'b0;
      wr_dq_en_q  <= 1'b0;
      if (ref_expire) ref_pend_q <= 1'b1;
      case (state_q)
        S_INIT_WAIT: begin
          if (cnt_q == 16'd0) begin
            cke_q   <= 1'b1;
            step_q  <= 3'd0;
            state_q <= S_INIT_SEQ;
          end else begin
            cmd_q <= CMD_DESEL;
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_INIT_SEQ: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (step_q == 3'd7) begin
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cmd_q  <= seq_cmd;
            ba_q   <= seq_ba;
            addr_q <= seq_addr;
            cnt_q  <= seq_wait;
            step_q <= step_q + 3'd1;
          end
        end
        S_IDLE: begin
          if (ref_pend_q) begin
            cmd_q   <= CMD_REF;
            cnt_q   <= RFC_W;
            state_q <= S_REF;
          end else if (accept) begin
            wr_q        <= req_write;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
            lat_be_q    <= req_be;
            cmd_q       <= CMD_ACT;
            ba_q        <= req_addr[9:8];
            addr_q      <= req_addr[20:10];
            cnt_q       <= RCD_W;
            state_q     <= S_ACT;
          end
        end
        S_REF: begin
          if (cnt_q == 16'd0) begin
            ref_pend_q <= ref_expire;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_ACT: begin
          if (cnt_q == 16'd0) begin
            cmd_q   <= wr_q ? CMD_WR : CMD_RD;
            ba_q    <= lat_addr_q[9:8];
            addr_q  <= {2'b10, lat_addr_q[7:0], 1'b0};
            state_q <= S_RDWR;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_RDWR: begin
          if (wr_q) begin
            wr_dq_en_q  <= 1'b1;
            rsp_valid_q <= 1'b1;
            wr_dq_p_q   <= lat_wdata_q[15:0];
            wr_dq_n_q   <= lat_wdata_q[31:16];
            wr_dm_p_q   <= ~lat_be_q[1:0];
            wr_dm_n_q   <= ~lat_be_q[3:2];
            state_q     <= S_WR_DATA;
          end else begin
            cnt_q   <= RD_W;
            state_q <= S_RD_DATA;
          end
        end
        S_WR_DATA: begin
          cnt_q   <= WRP_W;
          state_q <= S_PRE_WAIT;
        end
        S_RD_DATA: begin
          if (cnt_q == 16'd0) begin
            rsp_rdata_q <= {rd_dq_n, rd_dq_p};
            rsp_valid_q <= 1'b1;
            cnt_q       <= RP_W;
            state_q     <= S_PRE_WAIT;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_PRE_WAIT: begin
          if (cnt_q == 16'd0) state_q <= S_IDLE;
          else                cnt_q   <= cnt_q - 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
  assign sd_cke    = cke_q;
  assign sd_ba     = ba_q;
  assign sd_addr   = addr_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr_dq_en  = wr_dq_en_q;
  assign wr_dq_p   = wr_dq_p_q;
  assign wr_dq_n   = wr_dq_n_q;
  assign wr_dm_p   = wr_dm_p_q;
  assign wr_dm_n   = wr_dm_n_q;

`ifdef DDR_STAT_CNT_EN
  logic [15:0] stat_req_q, stat_ref_q;

  // Only refreshes issued from IDLE count; the two init refreshes are excluded.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stat_req_q <= '0;
      stat_ref_q <= '0;
    end else begin
      if (accept && stat_req_q != 16'hFFFF) stat_req_q <= stat_req_q + 16'd1;
      if (state_q == S_IDLE && ref_pend_q && stat_ref_q != 16'hFFFF) stat_ref_q <= stat_ref_q + 16'd1;
    end
  end

  assign stat_req_cnt = stat_req_q;
  assign stat_ref_cnt = stat_ref_q;
`endif

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer: init sequence, writes/reads with masks, refresh priority, mid-read reset.
`timescale 1ns/1ps
module tb_ddr_cmd_sequencer;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [20:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic [15:0] rd_dq_p = 16'hDEAD, rd_dq_n = 16'hBEEF;
  logic        req_ready, rsp_valid, init_done, sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, wr_dq_en;
  logic [31:0] rsp_rdata;
  logic [1:0]  sd_ba, wr_dm_p, wr_dm_n;
  logic [10:0] sd_addr;
  logic [15:0] wr_dq_p, wr_dq_n;
  logic [3:0]  cmd;
`ifdef DDR_STAT_CNT_EN
  logic [15:0] stat_req_cnt, stat_ref_cnt;
`endif

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] mem [logic [20:0]];

  logic [3:0]  e_cmd  [7] = '{C_PRE, C_MRS, C_MRS, C_PRE, C_REF, C_REF, C_MRS};
  logic [1:0]  e_ba   [7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [10:0] e_addr [7] = '{11'h400, 11'h000, 11'h121, 11'h400, 11'h000, 11'h000, 11'h021};
  int          e_gap  [7] = '{1, 2, 2, 2, 2, 8, 8};

  assign cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

  always #5 HCLK = ~HCLK;

  ddr_cmd_sequencer dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sd_cke(sd_cke), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n),
    .sd_ba(sd_ba), .sd_addr(sd_addr),
    .wr_dq_en(wr_dq_en), .wr_dq_p(wr_dq_p), .wr_dq_n(wr_dq_n), .wr_dm_p(wr_dm_p), .wr_dm_n(wr_dm_n),
    .rd_dq_p(rd_dq_p), .rd_dq_n(rd_dq_n)
`ifdef DDR_STAT_CNT_EN
    , .stat_req_cnt(stat_req_cnt), .stat_ref_cnt(stat_ref_cnt)
`endif
  );

  task automatic tick();
    @(negedge HCLK);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the cycle after acceptance with the ACT command checked.
  task automatic start_req(input logic wr, input logic [20:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic [1:0] eba, input logic [10:0] erow, output int acc);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    while (!req_ready && n < 2000) begin tick(); n++; end
    chk("accept_bound", 32'(n < 2000), 32'd1);
    acc = cyc;
    tick();
    req_valid = 1'b0; req_write = ~wr; req_addr = '0; req_wdata = 32'h0; req_be = 4'h0;
    chk("act_cmd", 32'(cmd), 32'(C_ACT));
    chk("act_ba", 32'(sd_ba), 32'(eba));
    chk("act_row", 32'(sd_addr), 32'(erow));
  endtask

  task automatic do_write(input logic [20:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic [1:0] eba, input logic [10:0] erow, input logic [10:0] ecol,
                          input logic [1:0] edmp, input logic [1:0] edmn);
    int acc;
    logic [31:0] v;
    start_req(1'b1, a, wd, be, eba, erow, acc);
    tick();
    chk("wr_gap_nop", 32'(cmd), 32'(C_NOP));
    tick();
    chk("wr_cmd", 32'(cmd), 32'(C_WR));
    chk("wr_ba", 32'(sd_ba), 32'(eba));
    chk("wr_col", 32'(sd_addr), 32'(ecol));
    chk("wr_en_early", 32'(wr_dq_en), 32'd0);
    tick();
    chk("wr_en", 32'(wr_dq_en), 32'd1);
    chk("wr_rsp", 32'(rsp_valid), 32'd1);
    chk("wr_dq", {wr_dq_n, wr_dq_p}, wd);
    chk("wr_dm", {28'd0, wr_dm_n, wr_dm_p}, {28'd0, edmn, edmp});
    v = mem.exists(a) ? mem[a] : 32'h0BADF00D;
    if (!wr_dm_p[0]) v[7:0]   = wr_dq_p[7:0];
    if (!wr_dm_p[1]) v[15:8]  = wr_dq_p[15:8];
    if (!wr_dm_n[0]) v[23:16] = wr_dq_n[7:0];
    if (!wr_dm_n[1]) v[31:24] = wr_dq_n[15:8];
    mem[a] = v;
    tick();
    chk("wr_en_one_cycle", {30'd0, wr_dq_en, rsp_valid}, 32'd0);
  endtask

  task automatic do_read(input logic [20:0] a, input logic [1:0] eba, input logic [10:0] erow,
                         input logic [10:0] ecol, input logic [31:0] edata, output int acc);
    logic seen = 1'b0;
    logic [31:0] v;
    start_req(1'b0, a, 32'h0, 4'h0, eba, erow, acc);
    tick();
    tick();
    chk("rd_cmd", 32'(cmd), 32'(C_RD));
    chk("rd_ba", 32'(sd_ba), 32'(eba));
    chk("rd_col", 32'(sd_addr), 32'(ecol));
    v = mem.exists(a) ? mem[a] : 32'h0BADF00D;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
      if (k == 3) begin rd_dq_p = v[15:0]; rd_dq_n = v[31:16]; end
    end
    chk("rd_rsp_early", 32'(seen), 32'd0);
    tick();
    rd_dq_p = 16'hDEAD; rd_dq_n = 16'hBEEF;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_data", rsp_rdata, edata);
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("rd_data_hold", rsp_rdata, edata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int low, gap, d_cyc, acc, ref_c, n_act;
    logic early, seen;
    tick(); tick(); tick();
    HRESET = 1'b0;
    chk("rst_cke", 32'(sd_cke), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'hF);
    chk("rst_ba_addr", {19'd0, sd_ba, sd_addr}, 32'd0);
    chk("rst_flags", {28'd0, wr_dq_en, req_ready, rsp_valid, init_done}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    early = 1'b0;
    low = 0;
    while (sd_cke == 1'b0 && low < 30000) begin
      if (req_ready) early = 1'b1;
      low++;
      tick();
    end
    chk("init_cke_low_cycles", low, 32'd20000);
    chk("init_nop_after_cke", 32'(cmd), 32'(C_NOP));
    for (int i = 0; i < 7; i++) begin
      gap = 0;
      do begin
        tick();
        gap++;
        if (req_ready) early = 1'b1;
      end while (cmd == C_NOP && gap < 400);
      chk($sformatf("init_cmd%0d", i), 32'(cmd), 32'(e_cmd[i]));
      chk($sformatf("init_gap%0d", i), gap, e_gap[i]);
      chk($sformatf("init_ba%0d", i), 32'(sd_ba), 32'(e_ba[i]));
      if (e_cmd[i] != C_REF) chk($sformatf("init_addr%0d", i), 32'(sd_addr), 32'(e_addr[i]));
    end
    gap = 0;
    while (!init_done && gap < 400) begin
      if (req_ready) early = 1'b1;
      tick();
      gap++;
    end
    chk("init_done_gap", gap, 32'd200);
    chk("no_ready_before_init", 32'(early), 32'd0);
    chk("ready_at_init_done", 32'(req_ready), 32'd1);
    d_cyc = cyc;

    do_write(21'h00A0F, 32'hA5A5_5A5A, 4'b1111, 2'd2, 11'h002, 11'h41E, 2'b00, 2'b00);
    do_read (21'h00A0F, 2'd2, 11'h002, 11'h41E, 32'hA5A5_5A5A, acc);
    do_write(21'h00A0F, 32'h1122_3344, 4'b0100, 2'd2, 11'h002, 11'h41E, 2'b11, 2'b10);
    chk("rdata_unchanged_by_write", rsp_rdata, 32'hA5A5_5A5A);
    do_read (21'h00A0F, 2'd2, 11'h002, 11'h41E, 32'hA522_5A5A, acc);
    do_write(21'h1FFFFF, 32'hFFFF_FFFF, 4'b0000, 2'd3, 11'h7FF, 11'h5FE, 2'b11, 2'b11);
    do_read (21'h1FFFFF, 2'd3, 11'h7FF, 11'h5FE, 32'h0BAD_F00D, acc);

    // Request raised in the very cycle the first refresh becomes pending.
    chk("ref_not_passed", 32'(cyc < d_cyc + 780), 32'd1);
    while (cyc < d_cyc + 780) tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h00A0F;
    chk("ref_blocks_ready", 32'(req_ready), 32'd0);
    tick();
    chk("ref_cmd_first", 32'(cmd), 32'(C_REF));
    ref_c = cyc;
    do_read(21'h00A0F, 2'd2, 11'h002, 11'h41E, 32'hA522_5A5A, acc);
    chk("ref_to_accept", acc - ref_c, 32'd8);
    n_act = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (cmd == C_ACT) n_act++;
    end
    chk("no_duplicate_act", n_act, 32'd0);

    // Reset one cycle after RD: response must never appear.
    start_req(1'b0, 21'h00A0F, 32'h0, 4'h0, 2'd2, 11'h002, acc);
    tick();
    tick();
    chk("rst_rd_cmd", 32'(cmd), 32'(C_RD));
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("midrst_cke", 32'(sd_cke), 32'd0);
    chk("midrst_cmd", 32'(cmd), 32'hF);
    chk("midrst_flags", {28'd0, wr_dq_en, req_ready, rsp_valid, init_done}, 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    seen = 1'b0;
    low = 0;
    rd_dq_p = 16'h1234; rd_dq_n = 16'h5678;
    while (sd_cke == 1'b0 && low < 30000) begin
      if (rsp_valid) seen = 1'b1;
      low++;
      tick();
    end
    rd_dq_p = 16'hDEAD; rd_dq_n = 16'hBEEF;
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    chk("midrst_cke_low_cycles", low, 32'd20000);
    tick();
    chk("midrst_first_cmd", 32'(cmd), 32'(C_PRE));
    gap = 0;
    while (!init_done && gap < 500) begin tick(); gap++; end
    chk("midrst_init_done", 32'(init_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
